// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer and the up-counting stopwatch.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package timer_pkg;

   // 2-bit state encoding shared with the display/status path.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_PAUSE = ST_PAUSE,
      S_DONE  = ST_DONE
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // 0.1 s per count step at 100 MHz.
   localparam int DEFAULT_DVSR = 10_000_000;

   // Three BCD digits, hundreds first; same layout as the stopwatch display word.
   typedef struct packed {
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
   } bcd3_t;

   // Non-decimal nibbles from the switches are saturated to 9.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// One BCD digit of a ripple-borrow decrementer; chain three for 000..999.
// Latency: combinational.
// Backpressure: none.
// Ports: digit/borrow_in in; digit_next/borrow_out out (borrow_out = digit==0 && borrow_in).
module bcd_dec_digit
   import timer_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       borrow_in,
   output logic [3:0] digit_next,
   output logic       borrow_out
);

   always_comb begin
      digit_next = digit;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit == 4'd0) begin
            digit_next = BCD_MAX;
            borrow_out = 1'b1;
         end else begin
            digit_next = digit - 4'd1;
         end
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer with load/start/pause/clear and expiry pulse.
// Latency: commands take effect on the sampling edge; count steps every DVSR cycles in RUN.
// Backpressure: none; level commands, priority clr > load > start/pause.
// Ports: clk, reset_n (async low); clr, load, preset_in[11:0], start, pause;
//        d2/d1/d0 BCD count, running, done, expire_tick (one-cycle pulse).
// Build option: COUNTDOWN_AUTORELOAD_EN reloads the latched preset on expiry and keeps running.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int DVSR = DEFAULT_DVSR
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        load,
   input  logic [11:0] preset_in,
   input  logic        start,
   input  logic        pause,
   output logic [3:0]  d2,
   output logic [3:0]  d1,
   output logic [3:0]  d0,
   output logic        running,
   output logic        done,
   output logic        expire_tick
);

   localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;

   state_t         state_q, state_d;
   logic [PW-1:0]  psc_q, psc_d;
   bcd3_t          cnt_q, cnt_d;
   bcd3_t          preset_q, preset_d;
   logic           expire_q, expire_d;

   bcd3_t          preset_clamped;
   bcd3_t          dec;
   logic           b1, b2, underflow;
   logic           tick, cnt_zero, dec_zero;

   assign preset_clamped = '{d2: clamp_digit(preset_in[11:8]),
                             d1: clamp_digit(preset_in[7:4]),
                             d0: clamp_digit(preset_in[3:0])};

   assign tick     = (state_q == S_RUN) && (psc_q == PW'(DVSR - 1));
   assign cnt_zero = (cnt_q == '0);

   bcd_dec_digit u_dig0 (.digit(cnt_q.d0), .borrow_in(tick), .digit_next(dec.d0), .borrow_out(b1));
   bcd_dec_digit u_dig1 (.digit(cnt_q.d1), .borrow_in(b1),   .digit_next(dec.d1), .borrow_out(b2));
   bcd_dec_digit u_dig2 (.digit(cnt_q.d2), .borrow_in(b2),   .digit_next(dec.d2), .borrow_out(underflow));

   // Borrow out of the hundreds digit means the count was 000: never wrap to 999.
   assign dec_zero = !underflow && (dec == '0);

   always_comb begin
      state_d  = state_q;
      psc_d    = psc_q;
      cnt_d    = cnt_q;
      preset_d = preset_q;
      expire_d = 1'b0;
      if (clr) begin
         state_d  = S_IDLE;
         psc_d    = '0;
         cnt_d    = '0;
         preset_d = '0;
      end else if (load) begin
         state_d  = S_IDLE;
         psc_d    = '0;
         cnt_d    = preset_clamped;
         preset_d = preset_clamped;
      end else begin
         case (state_q)
            S_IDLE, S_PAUSE: begin
               if (start && !pause && !cnt_zero) state_d = S_RUN;
            end
            S_RUN: begin
               // Prescaler only advances here, so PAUSE resumes mid-period.
               psc_d = tick ? '0 : psc_q + PW'(1);
               if (pause && !start) state_d = S_PAUSE;
               if (tick && !underflow) begin
                  if (dec_zero) begin
                     expire_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                     // Reload instead of showing 000; state is left as decided above.
                     cnt_d = preset_q;
`else
                     cnt_d   = dec;
                     state_d = S_DONE;
`endif
                  end else begin
                     cnt_d = dec;
                  end
               end
            end
            default: ;  // DONE: only clr/load leave
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         psc_q    <= '0;
         cnt_q    <= '0;
         preset_q <= '0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         psc_q    <= psc_d;
         cnt_q    <= cnt_d;
         preset_q <= preset_d;
         expire_q <= expire_d;
      end
   end

   assign d2          = cnt_q.d2;
   assign d1          = cnt_q.d1;
   assign d0          = cnt_q.d0;
   assign running     = (state_q == S_RUN);
   assign done        = (state_q == S_DONE);
   assign expire_tick = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at DVSR=4; expectations are queued with a target cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clr, load, start, pause;
   logic [11:0] preset_in;
   logic [3:0]  d2, d1, d0;
   logic        running, done, expire_tick;

   countdown_timer #(.DVSR(4)) dut (
      .clk(clk), .reset_n(reset_n), .clr(clr), .load(load), .preset_in(preset_in),
      .start(start), .pause(pause), .d2(d2), .d1(d1), .d0(d0),
      .running(running), .done(done), .expire_tick(expire_tick)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [11:0] cnt;
      logic        run;
      logic        dn;
      logic        ex;
      string       nm;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;

   // Monitor: compares every queued expectation whose cycle has arrived.
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc || {d2, d1, d0} != e.cnt || running != e.run ||
             done != e.dn || expire_tick != e.ex) begin
            errors++;
            $display("FAIL %s @cyc %0d (want cyc %0d): got cnt=%h run=%b done=%b exp=%b, want cnt=%h run=%b done=%b exp=%b",
                     e.nm, cyc, e.cyc, {d2, d1, d0}, running, done, expire_tick,
                     e.cnt, e.run, e.dn, e.ex);
         end
      end
   end

   task automatic exp1(input int c, input logic [11:0] v, input logic r, input logic d,
                       input logic x, input string nm);
      exp_t n;
      n.cyc = c; n.cnt = v; n.run = r; n.dn = d; n.ex = x; n.nm = nm;
      sb.push_back(n);
   endtask

   task automatic expw(input int c0, input int c1, input logic [11:0] v, input logic r,
                       input logic d, input logic x, input string nm);
      for (int c = c0; c <= c1; c++) exp1(c, v, r, d, x, nm);
   endtask

   // Called at a negedge; inputs are sampled at the next posedge, returns at the following negedge.
   task automatic cmd(input logic c, input logic l, input logic s, input logic p,
                      input logic [11:0] pre);
      clr = c; load = l; start = s; pause = p; preset_in = pre;
      @(negedge clk);
      clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: stimulus did not complete, cyc=%0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   int E;

   initial begin
      reset_n = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; preset_in = '0;
      repeat (2) @(negedge clk);
      exp1(cyc + 1, 12'h000, 0, 0, 0, "reset_state");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Borrow chain 100 -> 099 -> 098, then load 000 while running.
      exp1(cyc + 1, 12'h100, 0, 0, 0, "load_100");
      cmd(0, 1, 0, 0, 12'h100);
      E = cyc + 1;
      expw(E, E + 3, 12'h100, 1, 0, 0, "bc_hold100");
      expw(E + 4, E + 7, 12'h099, 1, 0, 0, "bc_099");
      exp1(E + 8, 12'h098, 1, 0, 0, "bc_098");
      expw(E + 9, E + 13, 12'h000, 0, 0, 0, "load000_in_run");
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 8);
      cmd(0, 1, 0, 0, 12'h000);
      wait_until(E + 13);

      // Expiry from 002.
      exp1(cyc + 1, 12'h002, 0, 0, 0, "load_002");
      cmd(0, 1, 0, 0, 12'h002);
      E = cyc + 1;
      expw(E, E + 3, 12'h002, 1, 0, 0, "exp_002");
      expw(E + 4, E + 7, 12'h001, 1, 0, 0, "exp_001");
`ifdef COUNTDOWN_AUTORELOAD_EN
      exp1(E + 8, 12'h002, 1, 0, 1, "reload_1");
      expw(E + 9, E + 11, 12'h002, 1, 0, 0, "reload_002");
      expw(E + 12, E + 15, 12'h001, 1, 0, 0, "reload_001");
      exp1(E + 16, 12'h002, 1, 0, 1, "reload_2");
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 16);
`else
      exp1(E + 8, 12'h000, 0, 1, 1, "expire");
      expw(E + 9, E + 13, 12'h000, 0, 1, 0, "done_hold");
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 9);
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 13);
`endif

      // Pause two cycles into a period, hold, resume.
      exp1(cyc + 1, 12'h005, 0, 0, 0, "load_005");
      cmd(0, 1, 0, 0, 12'h005);
      E = cyc + 1;
      expw(E, E + 1, 12'h005, 1, 0, 0, "pz_run");
      expw(E + 2, E + 11, 12'h005, 0, 0, 0, "pz_paused");
      expw(E + 12, E + 13, 12'h005, 1, 0, 0, "pz_resumed");
      exp1(E + 14, 12'h004, 1, 0, 0, "pz_dec");
      expw(E + 15, E + 17, 12'h004, 1, 0, 0, "pz_004");
      exp1(E + 18, 12'h003, 1, 0, 0, "pz_003");
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 1);
      cmd(0, 0, 0, 1, 12'h000);
      wait_until(E + 5);
      cmd(0, 0, 1, 1, 12'h000);      // both high: stays paused
      wait_until(E + 11);
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 18);

      // Asynchronous reset mid-count at 123.
      exp1(cyc + 1, 12'h123, 0, 0, 0, "load_123");
      cmd(0, 1, 0, 0, 12'h123);
      E = cyc + 1;
      expw(E, E + 2, 12'h123, 1, 0, 0, "rst_pre");
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 2);
      @(posedge clk);
      #1;
      exp1(cyc, 12'h000, 0, 0, 0, "async_reset");
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp1(cyc + 1, 12'h000, 0, 0, 0, "post_reset");
      @(negedge clk);

      // Priority and clamping.
      exp1(cyc + 1, 12'h777, 0, 0, 0, "load_777");
      cmd(0, 1, 0, 0, 12'h777);
      exp1(cyc + 1, 12'h000, 0, 0, 0, "clr_beats_load");
      cmd(1, 1, 1, 0, 12'h555);
      exp1(cyc + 1, 12'h995, 0, 0, 0, "clamp_FA5");
      cmd(0, 1, 0, 0, 12'hFA5);
      exp1(cyc + 1, 12'h000, 0, 0, 0, "clr");
      cmd(1, 0, 0, 0, 12'h000);
      E = cyc + 1;
      expw(E, E + 3, 12'h000, 0, 0, 0, "start_at_000");
      cmd(0, 0, 1, 0, 12'h000);
      wait_until(E + 4);

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
